eqv_sweep_ctrl: RTL and testbench



---
 rtl/eqv_sweep_ctrl.sv | 138 +++++++++++++
 tb/tb_eqv_sweep_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/eqv_sweep_ctrl.sv
// Exhaustive equivalence sweep of two F implementations: SETTLE+2 cycles per vector, no backpressure (start/abort only).
// EQCHK_STOP_ON_FAIL_EN: end the sweep at the first mismatching vector instead of running all 2^N.
module eqv_sweep_ctrl #(
  parameter int N      = 3,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic         f_a,
  input  logic         f_b,
  output logic [N-1:0] vec,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   mismatch_cnt,
  output logic         first_fail_vld,
  output logic [N-1:0] first_fail_vec
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_COMPARE,
    S_DONE
  } state_e;

  localparam logic [3:0]   SETTLE_INIT = 4'(SETTLE);
  localparam logic [N-1:0] VEC_LAST    = '1;

  state_e       state_q, state_d;
  logic [N-1:0] vec_q, vec_d;
  logic [3:0]   settle_q, settle_d;
  logic [N:0]   mcnt_q, mcnt_d;
  logic         ffv_q, ffv_d;
  logic [N-1:0] ffvec_q, ffvec_d;
  logic         pass_q, pass_d;
  logic         mm;
  logic         stop_hit;

  assign mm = f_a ^ f_b;

`ifdef EQCHK_STOP_ON_FAIL_EN
  assign stop_hit = mm;
`else
  assign stop_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      mcnt_q   <= '0;
      ffv_q    <= 1'b0;
      ffvec_q  <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      mcnt_q   <= mcnt_d;
      ffv_q    <= ffv_d;
      ffvec_q  <= ffvec_d;
      pass_q   <= pass_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    mcnt_d   = mcnt_q;
    ffv_d    = ffv_q;
    ffvec_d  = ffvec_q;
    pass_d   = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          vec_d    = '0;
          settle_d = SETTLE_INIT;
          mcnt_d   = '0;
          ffv_d    = 1'b0;
          ffvec_d  = '0;
          pass_d   = 1'b0;
          state_d  = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          pass_d  = 1'b0;
          state_d = S_IDLE;
        end else if (settle_q != 4'd0) begin
          settle_d = settle_q - 4'd1;
        end else begin
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        // abort wins: this cycle's compare result is dropped
        if (abort) begin
          pass_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          if (mm) begin
            mcnt_d = mcnt_q + (N+1)'(1);
            if (!ffv_q) begin
              ffv_d   = 1'b1;
              ffvec_d = vec_q;
            end
          end
          if (stop_hit || (vec_q == VEC_LAST)) begin
            pass_d  = !stop_hit && (mcnt_q == '0) && !mm;
            state_d = S_DONE;
          end else begin
            vec_d    = vec_q + N'(1);
            settle_d = SETTLE_INIT;
            state_d  = S_SETTLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_SETTLE) || (state_q == S_COMPARE);
    done = (state_q == S_DONE);
  end

  assign vec            = vec_q;
  assign pass           = pass_q;
  assign mismatch_cnt   = mcnt_q;
  assign first_fail_vld = ffv_q;
  assign first_fail_vec = ffvec_q;

endmodule

// File: tb/tb_eqv_sweep_ctrl.sv
// Directed bench for eqv_sweep_ctrl at N=3, SETTLE=1; f_b derived from f_a per test mode.
module tb_eqv_sweep_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       f_a;
  logic       f_b;
  logic [2:0] vec;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] mismatch_cnt;
  logic       first_fail_vld;
  logic [2:0] first_fail_vec;

  int n_checks = 0;
  int n_err    = 0;
  int mode     = 0;

  eqv_sweep_ctrl #(.N(3), .SETTLE(1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .f_a            (f_a),
    .f_b            (f_b),
    .vec            (vec),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .mismatch_cnt   (mismatch_cnt),
    .first_fail_vld (first_fail_vld),
    .first_fail_vec (first_fail_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode 0: identical, 1: differ at vec 5 and 6, 2: inverted
  always_comb begin
    f_a = ^vec;
    case (mode)
      1:       f_b = f_a ^ ((vec == 3'd5) || (vec == 3'd6));
      2:       f_b = ~f_a;
      default: f_b = f_a;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      cyc++;
      if (done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_vec(input logic [2:0] target);
    for (int i = 0; i < 100 && vec != target; i++) tick();
    chk("vec_reached", vec, target);
  endtask

  initial begin
    int  cyc;
    bit  flag;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    tick();
    tick();
    chk("rst_vec", vec, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_mcnt", mismatch_cnt, 0);
    chk("rst_ffv", first_fail_vld, 0);
    rst_n = 1'b1;
    tick();

    // identical functions: each vector held 3 cycles, done 24 edges after start
    mode = 0;
    pulse_start();
    flag = 1'b0;
    for (int j = 0; j < 24; j++) begin
      chk("sweep_vec", vec, j / 3);
      chk("sweep_busy", busy, 1);
      if (done) flag = 1'b1;
      tick();
    end
    chk("early_done", flag, 0);
    chk("eq_done", done, 1);
    chk("eq_busy", busy, 0);
    chk("eq_pass", pass, 1);
    chk("eq_mcnt", mismatch_cnt, 0);
    chk("eq_ffv", first_fail_vld, 0);
    chk("eq_vec", vec, 7);
    tick();
    chk("eq_done_pulse", done, 0);
    chk("eq_pass_hold", pass, 1);

    // mismatches at vectors 5 and 6
    mode = 1;
    pulse_start();
    chk("m1_pass_clr", pass, 0);
    wait_done(cyc);
`ifdef EQCHK_STOP_ON_FAIL_EN
    chk("m1_cycles", cyc, 18);
    chk("m1_mcnt", mismatch_cnt, 1);
    chk("m1_vec", vec, 5);
`else
    chk("m1_cycles", cyc, 24);
    chk("m1_mcnt", mismatch_cnt, 2);
    chk("m1_vec", vec, 7);
`endif
    chk("m1_pass", pass, 0);
    chk("m1_ffv", first_fail_vld, 1);
    chk("m1_ffvec", first_fail_vec, 5);
    tick();

    // every vector mismatches
    mode = 2;
    pulse_start();
    wait_done(cyc);
`ifdef EQCHK_STOP_ON_FAIL_EN
    chk("m2_cycles", cyc, 3);
    chk("m2_mcnt", mismatch_cnt, 1);
`else
    chk("m2_cycles", cyc, 24);
    chk("m2_mcnt", mismatch_cnt, 8);
`endif
    chk("m2_ffvec", first_fail_vec, 0);
    chk("m2_ffv", first_fail_vld, 1);
    chk("m2_pass", pass, 0);
    tick();

    // abort at vec 3; counters cleared by start
    mode = 1;
    pulse_start();
    chk("ab_mcnt_clr", mismatch_cnt, 0);
    chk("ab_ffv_clr", first_fail_vld, 0);
    wait_vec(3'd3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    chk("ab_pass", pass, 0);
    chk("ab_vec_hold", vec, 3);
    flag = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) flag = 1'b1;
    end
    chk("ab_stays_idle", flag, 0);
    mode = 0;
    pulse_start();
    chk("rs_vec", vec, 0);
    chk("rs_busy", busy, 1);
    wait_done(cyc);
    chk("rs_cycles", cyc, 24);
    chk("rs_pass", pass, 1);
    tick();

    // extra starts mid-sweep and in DONE are ignored
    pulse_start();
    for (int i = 0; i < 10; i++) tick();
    pulse_start();
    wait_done(cyc);
    chk("ig_cycles", cyc, 13);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ig_done_start", busy, 0);
    tick();
    chk("ig_idle", busy, 0);
    chk("ig_pass", pass, 1);

    // synchronous reset mid-sweep
`ifdef EQCHK_STOP_ON_FAIL_EN
    mode = 0;
`else
    mode = 2;
`endif
    pulse_start();
    wait_vec(3'd4);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mr_vec", vec, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_pass", pass, 0);
    chk("mr_mcnt", mismatch_cnt, 0);
    chk("mr_ffv", first_fail_vld, 0);
    chk("mr_ffvec", first_fail_vec, 0);
    flag = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) flag = 1'b1;
    end
    chk("mr_no_resume", flag, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
